// File: rtl/axi_wr_slave_model.sv
// ============================================================================
// Module  : axi_wr_slave_model
// Brief   : Reactive AXI3 write slave with a byte-strobed backing memory and
//           per-burst protocol checking (single outstanding burst).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_slave_model #(
    parameter int          MEM_AW     = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RESP_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       s_axi_awid,
    input  logic [31:0]       s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [11:0]       s_axi_wid,
    input  logic [63:0]       s_axi_wdata,
    input  logic [7:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [11:0]       s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [63:0]       dbg_data
);

    localparam logic [1:0]  c_FIXED    = 2'd0;
    localparam logic [1:0]  c_WRAP     = 2'd2;
    localparam logic [1:0]  c_RSVD     = 2'd3;
    localparam logic [32:0] c_SPAN     = 33'd1 << (MEM_AW + 3);
    localparam logic [3:0]  c_DLY_LAST = (RESP_DELAY == 0) ? 4'd0 : 4'(RESP_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state, w_next;
    logic        r_awready, r_wready, r_bvalid;
    logic [11:0] r_bid, r_id;
    logic [1:0]  r_bresp, r_burst;
    logic [2:0]  r_size;
    logic [7:0]  r_len, r_beat;
    logic [31:0] r_addr;
    logic        r_err;
    logic [3:0]  r_dly;
    logic [63:0] r_mem [2**MEM_AW];

    logic        w_aw_hs, w_w_hs, w_last_beat, w_legal, w_in_range, w_wrap_len_ok;
    logic        w_beat_err, w_err_acc;
    logic [31:0] w_bytes, w_wrap_sz, w_wrap_mask, w_off, w_addr_nxt;

    assign w_aw_hs     = s_axi_awvalid & r_awready;
    assign w_w_hs      = s_axi_wvalid & r_wready;
    assign w_last_beat = (r_beat == r_len);
    assign w_err_acc   = r_err | (w_w_hs & w_beat_err);

    always_comb begin
        w_bytes       = 32'd1 << r_size;
        w_wrap_sz     = ({24'd0, r_len} + 32'd1) << r_size;
        w_wrap_mask   = w_wrap_sz - 32'd1;
        w_off         = r_addr - BASE_ADDR;
        w_in_range    = (r_addr >= BASE_ADDR) && ({1'b0, w_off} < c_SPAN);
        w_legal       = !r_size[2] && (r_burst != c_RSVD) && w_in_range;
        w_wrap_len_ok = (r_len == 8'd1) || (r_len == 8'd3) || (r_len == 8'd7) || (r_len == 8'd15);
        case (r_burst)
            c_FIXED: w_addr_nxt = r_addr;
            c_WRAP:  w_addr_nxt = (r_addr & ~w_wrap_mask) | ((r_addr + w_bytes) & w_wrap_mask);
            default: w_addr_nxt = r_addr + w_bytes;
        endcase
        w_beat_err = !w_legal || (s_axi_wlast != w_last_beat) || (s_axi_wid != r_id)
                     || ((r_burst == c_WRAP) && !w_wrap_len_ok);
    end

    // Burst length alone ends DATA; wlast only feeds the error flag.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_aw_hs) w_next = S_DATA;
            S_DATA: if (w_w_hs && w_last_beat) w_next = (RESP_DELAY == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_dly == c_DLY_LAST) w_next = S_RESP;
            S_RESP: if (r_bvalid && s_axi_bready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= 12'd0;
            r_bresp   <= 2'd0;
            r_err     <= 1'b0;
            r_beat    <= 8'd0;
            r_dly     <= 4'd0;
            r_id      <= 12'd0;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_size    <= 3'd0;
            r_burst   <= 2'd0;
        end else begin
            r_state   <= w_next;
            r_awready <= (w_next == S_IDLE);
            r_wready  <= (w_next == S_DATA);
            r_bvalid  <= (w_next == S_RESP);
            if (w_aw_hs) begin
                r_id    <= s_axi_awid;
                r_addr  <= s_axi_awaddr;
                r_len   <= s_axi_awlen;
                r_size  <= s_axi_awsize;
                r_burst <= s_axi_awburst;
                r_beat  <= 8'd0;
                r_err   <= 1'b0;
            end
            if (w_w_hs) begin
                r_addr <= w_addr_nxt;
                r_beat <= r_beat + 8'd1;
                r_err  <= w_err_acc;
            end
            r_dly <= (r_state == S_WAIT) ? r_dly + 4'd1 : 4'd0;
            if (w_next == S_RESP && r_state != S_RESP) begin
                r_bid   <= r_id;
                r_bresp <= w_err_acc ? 2'b10 : 2'b00;
            end
        end
    end

    // Memory is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && w_w_hs && w_legal) begin
            for (int i = 0; i < 8; i++) begin
                if (s_axi_wstrb[i])
                    r_mem[w_off[MEM_AW+2:3]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign dbg_data      = r_mem[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_slave_model.sv
// ============================================================================
// Module  : tb_axi_wr_slave_model
// Brief   : Directed bench for axi_wr_slave_model; B responses checked by a
//           queue-based scoreboard monitor, memory checked via the backdoor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_wr_slave_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [11:0] wid = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [7:0]  dbg_addr = '0;
    logic [63:0] dbg_data;

    int n_chk  = 0;
    int n_pass = 0;
    logic [13:0] exp_q[$];
    logic [63:0] d[16];
    logic [7:0]  s[16];
    logic [63:0] saved;

    axi_wr_slave_model dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic rd(input int word, output logic [63:0] val);
        dbg_addr = 8'(word);
        #1;
        val = dbg_data;
    endtask

    task automatic chk_mem(input string name, input int word, input logic [63:0] exp);
        logic [63:0] v;
        rd(word, v);
        chk(name, v, exp);
    endtask

    // Scoreboard monitor: every accepted B must match the oldest expectation.
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_b", {50'd0, bid, bresp}, 64'hDEAD);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                chk("b_id", {52'd0, bid}, {52'd0, e[13:2]});
                chk("b_resp", {62'd0, bresp}, {62'd0, e[1:0]});
            end
        end
    end

    task automatic write_burst(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                               input logic [1:0] exp_resp, input bit stall);
        bit ok;
        int n;
        exp_q.push_back({id, exp_resp});
        if (stall) bready = 1'b0;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        if (!ok) chk("aw_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = d[b]; wstrb = s[b]; wid = id;
            wlast = (wlast_at < 0) ? (b == int'(len)) : (b == wlast_at);
            ok = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (wready) begin ok = 1; break; end
            end
            if (!ok) chk("w_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bvalid) break;
        end
        chk("b_latency", 64'(n), 64'd3);
        if (stall) begin
            repeat (5) begin
                @(negedge clk);
                chk("stall_bvalid", {63'd0, bvalid}, 64'd1);
                chk("stall_bid", {52'd0, bid}, {52'd0, id});
                chk("stall_bresp", {62'd0, bresp}, {62'd0, exp_resp});
                chk("stall_awready", {63'd0, awready}, 64'd0);
            end
            @(posedge clk); #1;
            bready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_wready", {63'd0, wready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_bid_bresp", {50'd0, bid, bresp}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // INCR, four full beats at 0x10 -> words 2..5
        d[0] = 64'h1111_1111_1111_1111; d[1] = 64'h2222_2222_2222_2222;
        d[2] = 64'h3333_3333_3333_3333; d[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 16; i++) s[i] = 8'hFF;
        write_burst(12'h123, 32'h10, 8'd3, 3'd3, 2'd1, -1, 2'b00, 0);
        chk_mem("incr_w2", 2, 64'h1111_1111_1111_1111);
        chk_mem("incr_w3", 3, 64'h2222_2222_2222_2222);
        chk_mem("incr_w4", 4, 64'h3333_3333_3333_3333);
        chk_mem("incr_w5", 5, 64'h4444_4444_4444_4444);

        // WRAP from 0x18 over a 32-byte window -> words 3,0,1,2
        for (int i = 0; i < 4; i++) d[i] = {8{8'(8'hC0 + i)}};
        write_burst(12'h456, 32'h18, 8'd3, 3'd3, 2'd2, -1, 2'b00, 0);
        chk_mem("wrap_w3", 3, 64'hC0C0_C0C0_C0C0_C0C0);
        chk_mem("wrap_w0", 0, 64'hC1C1_C1C1_C1C1_C1C1);
        chk_mem("wrap_w1", 1, 64'hC2C2_C2C2_C2C2_C2C2);
        chk_mem("wrap_w2", 2, 64'hC3C3_C3C3_C3C3_C3C3);

        // FIXED, two half-word strobed beats into word 1
        d[0] = 64'hAAAA_AAAA_AAAA_AAAA; s[0] = 8'h0F;
        d[1] = 64'h5555_5555_5555_5555; s[1] = 8'hF0;
        write_burst(12'h00F, 32'h8, 8'd1, 3'd3, 2'd0, -1, 2'b00, 0);
        chk_mem("fixed_w1", 1, 64'h5555_5555_AAAA_AAAA);
        for (int i = 0; i < 16; i++) s[i] = 8'hFF;

        // Early wlast: all three beats still taken, SLVERR
        d[0] = {8{8'hD0}}; d[1] = {8{8'hD1}}; d[2] = {8{8'hD2}};
        write_burst(12'h321, 32'h40, 8'd2, 3'd3, 2'd1, 1, 2'b10, 0);
        chk_mem("wlast_w10", 10, {8{8'hD2}});

        // Out of range: offset 0x800 would alias word 0 if not suppressed
        rd(0, saved);
        d[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        write_burst(12'h801, 32'h800, 8'd0, 3'd3, 2'd1, -1, 2'b10, 0);
        chk_mem("oor_w0", 0, saved);

        // Reserved burst type
        rd(12, saved);
        d[0] = {8{8'hEE}};
        write_burst(12'h333, 32'h60, 8'd0, 3'd3, 2'd3, -1, 2'b10, 0);
        chk_mem("rsvd_w12", 12, saved);

        // Response stall with bready low
        d[0] = {8{8'h77}};
        write_burst(12'h7AB, 32'h30, 8'd0, 3'd3, 2'd1, -1, 2'b00, 1);
        chk_mem("stall_w6", 6, {8{8'h77}});

        // Reset during beat 2 of an INCR burst at 0x80 (words 16..19)
        @(posedge clk); #1;
        awid = 12'h0F0; awaddr = 32'h80; awlen = 8'd3; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
        begin
            bit ok;
            ok = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (awready) begin ok = 1; break; end
            end
            if (!ok) chk("abort_aw_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            awvalid = 1'b0;
            for (int b = 0; b < 2; b++) begin
                wvalid = 1'b1; wid = 12'h0F0; wstrb = 8'hFF; wlast = 1'b0;
                wdata = {8{8'(8'hB0 + b)}};
                ok = 0;
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (wready) begin ok = 1; break; end
                end
                if (!ok) chk("abort_w_timeout", 64'd0, 64'd1);
                @(posedge clk); #1;
            end
        end
        wdata = {8{8'hB2}};
        rst = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        chk("abort_awready", {63'd0, awready}, 64'd0);
        chk("abort_wready", {63'd0, wready}, 64'd0);
        chk("abort_bvalid", {63'd0, bvalid}, 64'd0);
        chk("abort_bid_bresp", {50'd0, bid, bresp}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_mem("abort_w16", 16, {8{8'hB0}});
        chk_mem("abort_w17", 17, {8{8'hB1}});

        // Fresh burst after reset release
        d[0] = {8{8'h99}};
        write_burst(12'h0AA, 32'h20, 8'd0, 3'd3, 2'd1, -1, 2'b00, 0);
        chk_mem("post_rst_w4", 4, {8{8'h99}});

        repeat (4) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
